// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table extractor and its settle counter.
// No logic of its own; the row-write helper keeps the MSB-first bit ordering in one place.
package tt_pkg;

    localparam int TT_ROWS        = 8;
    localparam int TT_SEL_W       = 3;
    localparam int SETTLE_DEFAULT = 2;
    localparam int SETTLE_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Row 000 lives in the MSB, row 111 in the LSB.
    function automatic logic [TT_ROWS-1:0] tt_set_row(
        input logic [TT_ROWS-1:0]  tbl,
        input logic [TT_SEL_W-1:0] row,
        input logic                bit_val
    );
        logic [TT_ROWS-1:0] r;
        r = tbl;
        r[TT_SEL_W'(TT_ROWS-1) - row] = bit_val;
        return r;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Per-row dwell counter: counts 0..settle while enabled, flags the final cycle, then wraps to 0.
// One-cycle registered count, last is combinational from it; clr overrides en, no backpressure.
module tt_settle_counter
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [SETTLE_W-1:0] settle,
    output logic                last
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    assign last = (cnt_q == settle);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_extractor.sv
// Sweeps stim through rows 000..111, holds each SETTLE+1 cycles, samples dut_out into an 8-bit truth table.
// 8*(SETTLE+1) busy cycles then a one-cycle done; start ignored unless IDLE. TT_EXTRACT_CHECK_EN adds match.
module tt_extractor
    import tt_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] stim,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    input  logic [7:0] exp_table,
    output logic       match
);

    tt_state_e state_q;
    tt_state_e state_d;

    logic [TT_SEL_W-1:0] stim_q;
    logic [TT_SEL_W-1:0] stim_d;
    logic [TT_ROWS-1:0]  shadow_q;
    logic [TT_ROWS-1:0]  shadow_d;
    logic [TT_ROWS-1:0]  shadow_set;
    logic [TT_ROWS-1:0]  table_q;
    logic [TT_ROWS-1:0]  table_d;

    logic row_last;
    logic row_done;
    logic final_row;
    logic launch;

    tt_settle_counter u_settle (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != RUN),
        .en     (state_q == RUN),
        .settle (SETTLE_W'(SETTLE)),
        .last   (row_last)
    );

    assign launch     = (state_q == IDLE) && start;
    assign row_done   = (state_q == RUN) && row_last;
    assign final_row  = row_done && (stim_q == TT_SEL_W'(TT_ROWS-1));
    assign shadow_set = tt_set_row(shadow_q, stim_q, dut_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (final_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        stim      = stim_q;
        table_out = table_q;
    end

    // Row 111 is terminal: the counter is forced back to 000 instead of wrapping.
    always_comb begin
        stim_d = stim_q;
        if (row_done) begin
            stim_d = final_row ? '0 : stim_q + 3'd1;
        end
        if (state_q != RUN) begin
            stim_d = '0;
        end
    end

    // The shadow absorbs the sweep; table_out only ever sees a complete table.
    always_comb begin
        shadow_d = shadow_q;
        table_d  = table_q;
        if (launch) begin
            shadow_d = '0;
        end else if (row_done) begin
            shadow_d = shadow_set;
        end
        if (final_row) begin
            table_d = shadow_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim_q   <= '0;
            shadow_q <= '0;
            table_q  <= '0;
        end else begin
            stim_q   <= stim_d;
            shadow_q <= shadow_d;
            table_q  <= table_d;
        end
    end

`ifdef TT_EXTRACT_CHECK_EN
    logic match_q;
    logic match_d;

    always_comb begin
        match_d = match_q;
        if (final_row) begin
            match_d = (shadow_set == exp_table);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`else
    logic unused_exp_table;

    assign unused_exp_table = ^exp_table;
    assign match            = 1'b0;
`endif

endmodule
